// File: rtl/adc_avg_pkg.sv
// rtl/adc_avg_pkg.sv - shared constants, FSM states and shift clamp for the averaging decimator
package adc_avg_pkg;

    localparam int DEF_MAX_SHIFT = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } avg_state_t;

    function automatic int clamp_shift(input int shift, input int max_shift);
        return (shift > max_shift) ? max_shift : shift;
    endfunction

endpackage

// File: rtl/adc_avg_decim_if.sv
// rtl/adc_avg_decim_if.sv - valid/ready result stream carrying averaged sample and sequence number
interface adc_avg_decim_if #(
    parameter int SEQ_W = 8
) ();
    logic [15:0]      out_data;
    logic [SEQ_W-1:0] out_seq;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_seq,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_seq,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/adc_avg_obuf.sv
// rtl/adc_avg_obuf.sv - 2-entry result FIFO with registered head and same-cycle read/write
module adc_avg_obuf #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         full,
    output logic         head_valid,
    output logic [W-1:0] head_data
);
    logic [W-1:0] tail;
    logic [1:0]   count;
    logic         rd;

    assign rd         = rd_en && (count != 2'd0);
    assign full       = (count == 2'd2);
    assign head_valid = (count != 2'd0);

    // A write while full and not read is simply not taken; the caller counts it as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            head_data <= '0;
            tail      <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (wr_en) begin
                        head_data <= wr_data;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (rd && wr_en) begin
                        head_data <= wr_data;
                    end else if (rd) begin
                        count <= 2'd0;
                    end else if (wr_en) begin
                        tail  <= wr_data;
                        count <= 2'd2;
                    end
                end
                2'd2: begin
                    if (rd) begin
                        head_data <= tail;
                        if (wr_en) begin
                            tail <= wr_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end
endmodule

// File: rtl/adc_avg_decim.sv
// rtl/adc_avg_decim.sv - boxcar-averaging decimator over 2^shift samples with buffered, drop-counted output
module adc_avg_decim
    import adc_avg_pkg::*;
#(
    parameter int MAX_SHIFT = DEF_MAX_SHIFT,
    parameter int SEQ_W     = 8,
    localparam int SH_W     = $clog2(MAX_SHIFT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [SH_W-1:0]  cfg_shift,
    input  logic [15:0]      adc_data,
    input  logic             adc_data_en,
    adc_avg_decim_if.master  res,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [15:0]      drop_cnt
);
    localparam int ACC_W = 16 + MAX_SHIFT;
    localparam int CNT_W = MAX_SHIFT + 1;

    avg_state_t        state;
    logic [SH_W-1:0]   shift_q;
    logic [SH_W-1:0]   shift_next;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  win_last;
    logic [SEQ_W-1:0]  seq;
    logic [15:0]       result;
    logic              take;
    logic              win_done;
    logic              fifo_full;
    logic              fifo_rd;
    logic              drop;
    logic [15+SEQ_W:0] head;

    assign shift_next = SH_W'(clamp_shift(int'(cfg_shift), MAX_SHIFT));
    assign take       = (state == ACCUM) && enable && adc_data_en;
    assign win_last   = (CNT_W'(1) << shift_q) - CNT_W'(1);
    assign win_done   = take && (cnt == win_last);
    assign sum        = acc + ACC_W'(adc_data);
    assign result     = 16'(sum >> shift_q);
    assign fifo_rd    = res.out_valid && res.out_ready;
    assign drop       = win_done && fifo_full && !fifo_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            acc     <= '0;
            cnt     <= '0;
            seq     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= ACCUM;
                        shift_q <= shift_next;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                ACCUM: begin
                    // Dropping enable wins over a same-cycle strobe; that sample is discarded too.
                    if (!enable) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (win_done) begin
                        acc     <= '0;
                        cnt     <= '0;
                        seq     <= seq + SEQ_W'(1);
                        shift_q <= shift_next;
                    end else if (take) begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (drop) begin
            ovf_sticky <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    adc_avg_obuf #(
        .W(16 + SEQ_W)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (win_done),
        .wr_data   ({result, seq}),
        .rd_en     (res.out_ready),
        .full      (fifo_full),
        .head_valid(res.out_valid),
        .head_data (head)
    );

    assign res.out_data = head[15+SEQ_W:SEQ_W];
    assign res.out_seq  = head[SEQ_W-1:0];
endmodule

// File: tb/tb_adc_avg_decim.sv
// tb/tb_adc_avg_decim.sv - self-checking bench for adc_avg_decim
module tb_adc_avg_decim;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  cfg_shift;
    logic [15:0] adc_data;
    logic        adc_data_en;
    logic        ovf_sticky;
    logic        ovf_clr;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    adc_avg_decim_if #(.SEQ_W(8)) res_if ();

    adc_avg_decim #(
        .MAX_SHIFT(6),
        .SEQ_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_shift  (cfg_shift),
        .adc_data   (adc_data),
        .adc_data_en(adc_data_en),
        .res        (res_if.master),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .drop_cnt   (drop_cnt)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  seq;
    } exp_t;

    typedef struct {
        logic [2:0]  shift;
        int          n;
        logic [15:0] base;
        logic [15:0] step;
        logic [15:0] last;
        logic [15:0] exp;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[6];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  m_seq;
    logic [15:0] m_drops;
    logic        m_ovf;
    logic        pend;
    logic [15:0] pend_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on handshake, then account for a result completing on the coming edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (res_if.out_valid && res_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got seq %0d data 0x%0h, expected none", res_if.out_seq, res_if.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(res_if.out_data), 32'(e.data));
                chk("out_seq", 32'(res_if.out_seq), 32'(e.seq));
            end
        end
        if (pend) begin
            if (exp_q.size() >= 2) begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops++;
            end else begin
                e.data = pend_data;
                e.seq  = m_seq;
                exp_q.push_back(e);
            end
            m_seq++;
            pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] d, input logic last, input logic [15:0] e);
        adc_data    = d;
        adc_data_en = 1'b1;
        if (last) begin
            pend      = 1'b1;
            pend_data = e;
        end
        tick();
        adc_data_en = 1'b0;
    endtask

    task automatic start(input logic [2:0] sh);
        enable = 1'b0;
        tick();
        cfg_shift = sh;
        enable    = 1'b1;
        tick();
    endtask

    task automatic drain();
        res_if.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_seq   = 8'd0;
        m_drops = 16'd0;
        m_ovf   = 1'b0;
        pend    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{shift: 3'd2, n: 4,  base: 16'd100,   step: 16'd100, last: 16'd400,   exp: 16'd250};
        vecs[1] = '{shift: 3'd6, n: 64, base: 16'hFFFF,  step: 16'd0,   last: 16'hFFFF,  exp: 16'hFFFF};
        vecs[2] = '{shift: 3'd6, n: 64, base: 16'd0,     step: 16'd0,   last: 16'd63,    exp: 16'd0};
        vecs[3] = '{shift: 3'd1, n: 2,  base: 16'd7,     step: 16'd0,   last: 16'd8,     exp: 16'd7};
        vecs[4] = '{shift: 3'd3, n: 8,  base: 16'd10,    step: 16'd1,   last: 16'd17,    exp: 16'd13};
        vecs[5] = '{shift: 3'd7, n: 64, base: 16'd2,     step: 16'd0,   last: 16'd66,    exp: 16'd3};

        rst = 1'b1; enable = 1'b0; cfg_shift = 3'd0; adc_data = 16'd0;
        adc_data_en = 1'b0; ovf_clr = 1'b0; res_if.out_ready = 1'b1;
        clear_model();
        tick();
        tick();
        chk("rst_out_valid", 32'(res_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(res_if.out_data), 32'd0);
        chk("rst_out_seq", 32'(res_if.out_seq), 32'd0);
        chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Single 4-sample window: exact latency and a one-cycle valid pulse
        start(3'd2);
        feed(16'd100, 1'b0, 16'd0);
        feed(16'd200, 1'b0, 16'd0);
        feed(16'd300, 1'b0, 16'd0);
        chk("no_early_valid", 32'(res_if.out_valid), 32'd0);
        feed(16'd400, 1'b1, 16'd250);
        chk("lat_valid_rise", 32'(res_if.out_valid), 32'd1);
        chk("lat_data", 32'(res_if.out_data), 32'd250);
        tick();
        chk("valid_one_cycle", 32'(res_if.out_valid), 32'd0);
        drain();

        foreach (vecs[v]) begin
            start(vecs[v].shift);
            for (int i = 0; i < vecs[v].n; i++) begin
                if (i == vecs[v].n - 1) feed(vecs[v].last, 1'b1, vecs[v].exp);
                else feed(16'(vecs[v].base + 16'(i) * vecs[v].step), 1'b0, 16'd0);
            end
            drain();
        end

        // Pass-through at full rate
        do_reset();
        start(3'd0);
        for (int i = 1; i <= 16; i++) begin
            feed(16'(i), 1'b1, 16'(i));
            chk("pass_valid", 32'(res_if.out_valid), 32'd1);
            chk("pass_data", 32'(res_if.out_data), 32'(i));
        end
        drain();

        // Overflow: two buffered, third dropped, seq gap visible
        do_reset();
        res_if.out_ready = 1'b0;
        start(3'd0);
        feed(16'd1, 1'b1, 16'd1);
        feed(16'd2, 1'b1, 16'd2);
        feed(16'd3, 1'b1, 16'd3);
        chk("ovf_sticky_set", 32'(ovf_sticky), 32'(m_ovf));
        chk("drop_cnt_one", 32'(drop_cnt), 32'(m_drops));
        chk("hold_data", 32'(res_if.out_data), 32'd1);
        chk("hold_seq", 32'(res_if.out_seq), 32'd0);
        res_if.out_ready = 1'b1;
        tick();
        tick();
        feed(16'd4, 1'b1, 16'd4);
        chk("seq_after_gap", 32'(res_if.out_seq), 32'd3);
        drain();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        m_drops = 16'd0;
        chk("ovf_clr_sticky", 32'(ovf_sticky), 32'(m_ovf));
        chk("ovf_clr_cnt", 32'(drop_cnt), 32'(m_drops));

        // Abort a partial window; the strobe on the abort cycle is ignored
        start(3'd3);
        for (int i = 0; i < 5; i++) feed(16'd1000, 1'b0, 16'd0);
        enable = 1'b0; adc_data = 16'd9999; adc_data_en = 1'b1;
        tick();
        adc_data_en = 1'b0; enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) feed(16'd80, i == 7, 16'd80);
        drain();
        chk("abort_idle_valid", 32'(res_if.out_valid), 32'd0);

        // Shift change takes effect at the window boundary
        start(3'd2);
        feed(16'd10, 1'b0, 16'd0);
        feed(16'd20, 1'b0, 16'd0);
        cfg_shift = 3'd1;
        feed(16'd30, 1'b0, 16'd0);
        feed(16'd40, 1'b1, 16'd25);
        feed(16'd5, 1'b0, 16'd0);
        feed(16'd8, 1'b1, 16'd6);
        drain();

        // Reset with buffered results and a partial window
        do_reset();
        res_if.out_ready = 1'b0;
        start(3'd0);
        feed(16'd11, 1'b1, 16'd11);
        cfg_shift = 3'd2;
        feed(16'd12, 1'b1, 16'd12);
        feed(16'd13, 1'b0, 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("rst_mid_valid", 32'(res_if.out_valid), 32'd0);
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
        res_if.out_ready = 1'b1;
        start(3'd0);
        feed(16'd77, 1'b1, 16'd77);
        chk("post_rst_seq", 32'(res_if.out_seq), 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
